// File: rtl/datapath_pkg.sv
// Shared constants for the parametrised single-bus datapath: ALU op codes,
// bus-source offsets above the general registers, and the MUL/DIV FSM state.
package datapath_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  // Bus source codes are NREGS + one of these offsets.
  localparam int SRC_HI  = 0;
  localparam int SRC_LO  = 1;
  localparam int SRC_ZHI = 2;
  localparam int SRC_ZLO = 3;
  localparam int SRC_PC  = 4;
  localparam int SRC_MDR = 5;
  localparam int SRC_IMM = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/datapath_param_if.sv
// Control-unit <-> datapath signal bundle. The control unit is the master.
interface datapath_param_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  import datapath_pkg::*;

  localparam int RA_W  = $clog2(NREGS);
  localparam int SRC_W = $clog2(NREGS + 7);

  logic [SRC_W-1:0] bus_src;
  logic             reg_we;
  logic [RA_W-1:0]  reg_wsel;
  logic             PCin, IRin, MARin, Yin, HIin, LOin, MDRin;
  logic             read;
  logic [WIDTH-1:0] Mdatain;
  logic             Zin;
  logic [3:0]       alu_op;
  // MUL/DIV handshake: alu_start is sampled only while the engine is idle and
  // alu_op is MUL/DIV; alu_busy is high from that edge until Z is loaded, then
  // alu_done pulses for exactly one cycle while Z holds the result.
  logic             alu_start;
  logic             alu_busy;
  logic             alu_done;
  md_state_e        alu_state;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] ir_out, mar_out, mdr_out;

  modport master (
    output bus_src, reg_we, reg_wsel, PCin, IRin, MARin, Yin, HIin, LOin,
           MDRin, read, Mdatain, Zin, alu_op, alu_start,
    input  alu_busy, alu_done, alu_state, bus_out, ir_out, mar_out, mdr_out
  );

  modport slave (
    input  bus_src, reg_we, reg_wsel, PCin, IRin, MARin, Yin, HIin, LOin,
           MDRin, read, Mdatain, Zin, alu_op, alu_start,
    output alu_busy, alu_done, alu_state, bus_out, ir_out, mar_out, mdr_out
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative signed MUL (shift-add) / DIV (restoring) on operand magnitudes,
// one bit per cycle, with a final sign-fix cycle that loads the result.
module alu_muldiv_iter
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_load,
  output logic [2*WIDTH-1:0] o_result,
  output md_state_e          o_state
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e        r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_m, r_a;
  logic             r_div, r_neg_a, r_neg_b, r_b_zero;
  logic             w_last;
  logic [WIDTH:0]   w_sum, w_rem_t, w_diff;
  logic [WIDTH-1:0] w_quo, w_rem, w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_last  = (r_cnt == CNT_W'(WIDTH));
  assign w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_next = MD_RUN;
      MD_RUN:  if (w_last)  w_next = MD_DONE;
      MD_DONE: w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == MD_RUN);
    o_done  = (r_state == MD_DONE);
    o_load  = (r_state == MD_RUN) && w_last;
    o_state = r_state;
  end

  // MUL: {r_hi,r_lo} shifts right with r_m conditionally added into r_hi.
  // DIV: r_lo shifts dividend bits into the partial remainder r_hi.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_rem_t = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_rem_t - {1'b0, r_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_a      <= '0;
      r_div    <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (r_state == MD_IDLE && i_start) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_a      <= i_a;
      r_div    <= i_div;
      r_neg_a  <= i_a[WIDTH-1];
      r_neg_b  <= i_b[WIDTH-1];
      r_b_zero <= (i_b == '0);
      r_m      <= i_div ? w_abs_b : w_abs_a;
      r_lo     <= i_div ? w_abs_a : w_abs_b;
    end else if (r_state == MD_RUN && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        r_hi <= w_diff[WIDTH] ? w_rem_t[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = {r_hi, r_lo};
  assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem  = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    if (!r_div)        o_result = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    else if (r_b_zero) o_result = {r_a, {WIDTH{1'b1}}};
    else               o_result = {w_rem, w_quo};
  end

endmodule

// File: rtl/datapath_param.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR/Y/HI/LO, 2W-bit Z,
// single-cycle ALU, and the iterative MUL/DIV engine.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  parameter int IMM_W   = 19
) (
  input logic            clk,
  input logic            clear,
  datapath_param_if.slave dp
);
  localparam int RA_W  = $clog2(NREGS);
  localparam int SRC_W = $clog2(NREGS + 7);
  localparam int SH_W  = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_y, r_hi, r_lo, r_mdr;
  logic [2*WIDTH-1:0] r_z;

  logic [WIDTH-1:0]   w_bus, w_reg_rd, w_imm, w_alu;
  logic [SRC_W-1:0]   w_off;
  logic [SH_W-1:0]    w_sh;
  logic [2*WIDTH-1:0] w_ror, w_rol, w_md_result;
  logic               w_md_load, w_md_start, w_md_idle;

  assign w_imm = WIDTH'($signed(r_ir[IMM_W-1:0]));
  assign w_off = dp.bus_src - SRC_W'(NREGS);

  always_comb begin
    w_reg_rd = r_regs[dp.bus_src[RA_W-1:0]];
    if (R0_ZERO != 0 && dp.bus_src[RA_W-1:0] == '0) w_reg_rd = '0;
    w_bus = '0;
    if (dp.bus_src < SRC_W'(NREGS)) begin
      w_bus = w_reg_rd;
    end else begin
      case (w_off)
        SRC_W'(SRC_HI):  w_bus = r_hi;
        SRC_W'(SRC_LO):  w_bus = r_lo;
        SRC_W'(SRC_ZHI): w_bus = r_z[2*WIDTH-1:WIDTH];
        SRC_W'(SRC_ZLO): w_bus = r_z[WIDTH-1:0];
        SRC_W'(SRC_PC):  w_bus = r_pc;
        SRC_W'(SRC_MDR): w_bus = r_mdr;
        SRC_W'(SRC_IMM): w_bus = w_imm;
        default:         w_bus = '0;
      endcase
    end
  end

  // Rotates come from the doubled operand so a zero amount needs no special case.
  assign w_sh  = w_bus[SH_W-1:0];
  assign w_ror = {r_y, r_y} >> w_sh;
  assign w_rol = {r_y, r_y} << w_sh;

  always_comb begin
    w_alu = '0;
    case (dp.alu_op)
      OP_AND:  w_alu = r_y & w_bus;
      OP_OR:   w_alu = r_y | w_bus;
      OP_ADD:  w_alu = r_y + w_bus;
      OP_SUB:  w_alu = r_y - w_bus;
      OP_SHR:  w_alu = r_y >> w_sh;
      OP_SHL:  w_alu = r_y << w_sh;
      OP_ROR:  w_alu = w_ror[WIDTH-1:0];
      OP_ROL:  w_alu = w_rol[2*WIDTH-1:WIDTH];
      OP_SHRA: w_alu = WIDTH'($signed(r_y) >>> w_sh);
      OP_NEG:  w_alu = -w_bus;
      OP_NOT:  w_alu = ~w_bus;
      default: w_alu = '0;
    endcase
  end

  assign w_md_start = dp.alu_start && is_muldiv(dp.alu_op);
  assign w_md_idle  = (dp.alu_state == MD_IDLE);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (clear),
    .i_start  (w_md_start),
    .i_div    (dp.alu_op == OP_DIV),
    .i_a      (r_y),
    .i_b      (w_bus),
    .o_busy   (dp.alu_busy),
    .o_done   (dp.alu_done),
    .o_load   (w_md_load),
    .o_result (w_md_result),
    .o_state  (dp.alu_state)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (dp.reg_we && !(R0_ZERO != 0 && dp.reg_wsel == '0)) begin
      r_regs[dp.reg_wsel] <= w_bus;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_y   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_mdr <= '0;
    end else begin
      if (dp.PCin)  r_pc  <= w_bus;
      if (dp.IRin)  r_ir  <= w_bus;
      if (dp.MARin) r_mar <= w_bus;
      if (dp.Yin)   r_y   <= w_bus;
      if (dp.HIin)  r_hi  <= w_bus;
      if (dp.LOin)  r_lo  <= w_bus;
      if (dp.MDRin) r_mdr <= dp.read ? dp.Mdatain : w_bus;
    end
  end

  // Single-cycle Zin only lands while the engine is idle and the op is not MUL/DIV.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      r_z <= '0;
    else if (w_md_load)
      r_z <= w_md_result;
    else if (dp.Zin && w_md_idle && !is_muldiv(dp.alu_op))
      r_z <= {{WIDTH{1'b0}}, w_alu};
  end

  assign dp.bus_out = w_bus;
  assign dp.ir_out  = r_ir;
  assign dp.mar_out = r_mar;
  assign dp.mdr_out = r_mdr;

endmodule
